// File: rtl/pixel_dma_out_hls_deadlock_mon_mc_if.sv
// rtl/pixel_dma_out_hls_deadlock_mon_mc_if.sv - stall/idle inputs and detection outputs of the deadlock monitor
interface pixel_dma_out_hls_deadlock_mon_mc_if #(
  parameter int N_AXIS = 1,
  parameter int N_INST = 2,
  parameter int CNT_W  = 16,
  parameter int IDX_W  = (N_AXIS + N_INST > 1) ? $clog2(N_AXIS + N_INST) : 1
);
  logic                clear;
  logic [N_AXIS-1:0]   axis_block_sigs;
  logic [N_INST-1:0]   inst_idle_sigs;
  logic [N_INST-1:0]   inst_block_sigs;
  logic                block;
  logic [IDX_W-1:0]    block_src_idx;
  logic [CNT_W-1:0]    block_cycles;

  modport master (
    output clear, axis_block_sigs, inst_idle_sigs, inst_block_sigs,
    input  block, block_src_idx, block_cycles
  );

  modport slave (
    input  clear, axis_block_sigs, inst_idle_sigs, inst_block_sigs,
    output block, block_src_idx, block_cycles
  );
endinterface

// File: rtl/pixel_dma_out_hls_deadlock_mon_mc.sv
// rtl/pixel_dma_out_hls_deadlock_mon_mc.sv - persistence-filtered deadlock monitor for HLS dataflow regions
// Define HLS_DEADLOCK_MON_STICKY_EN to latch block until clear/reset.
module pixel_dma_out_hls_deadlock_mon_mc #(
  parameter int                N_AXIS    = 1,
  parameter int                N_INST    = 2,
  parameter int                THRESH    = 1,
  parameter int                CNT_W     = 16,
  parameter logic [N_AXIS-1:0] AXIS_MASK = {N_AXIS{1'b1}},
  parameter int                IDX_W     = (N_AXIS + N_INST > 1) ? $clog2(N_AXIS + N_INST) : 1
) (
  input  logic                                 clock,
  input  logic                                 reset,
  pixel_dma_out_hls_deadlock_mon_mc_if.slave   mon
);

  localparam logic [CNT_W-1:0] THR     = CNT_W'(THRESH);
  localparam logic [CNT_W-1:0] THR_M1  = CNT_W'(THRESH - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] pcnt_q, pcnt_d;
  logic             block_q, block_d;
  logic [IDX_W-1:0] src_q, src_d;
  logic [CNT_W-1:0] cycles_q, cycles_d;

  logic             cand;
  logic             det;
  logic             reach;
  logic [IDX_W-1:0] src_idx;

  // pcnt saturates at THR, so "pcnt >= THR-1" is exactly one of these two values.
  always_comb begin
    cand  = (|(mon.axis_block_sigs & AXIS_MASK) | (|mon.inst_block_sigs))
            & ~(&mon.inst_idle_sigs);
    det   = cand & (pcnt_q == THR_M1);
    reach = cand & ((pcnt_q == THR_M1) | (pcnt_q == THR));
  end

  // Scan high-to-low so the lowest asserted source wins; AXIS bits outrank inst bits.
  always_comb begin
    src_idx = '0;
    for (int j = N_INST - 1; j >= 0; j--) begin
      if (mon.inst_block_sigs[j]) src_idx = IDX_W'(N_AXIS + j);
    end
    for (int i = N_AXIS - 1; i >= 0; i--) begin
      if (mon.axis_block_sigs[i] & AXIS_MASK[i]) src_idx = IDX_W'(i);
    end
  end

  always_comb begin
    pcnt_d   = pcnt_q;
    block_d  = block_q;
    src_d    = src_q;
    cycles_d = cycles_q;
    if (mon.clear) begin
      pcnt_d   = '0;
      block_d  = 1'b0;
      src_d    = '0;
      cycles_d = '0;
    end else begin
      if (!cand)              pcnt_d = '0;
      else if (pcnt_q == THR) pcnt_d = THR;
      else                    pcnt_d = pcnt_q + 1'b1;
      if (det && !block_q) src_d = src_idx;
`ifdef HLS_DEADLOCK_MON_STICKY_EN
      block_d = block_q | reach;
`else
      block_d = reach;
`endif
      if (block_q && (cycles_q != CNT_MAX)) cycles_d = cycles_q + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pcnt_q   <= '0;
      block_q  <= 1'b0;
      src_q    <= '0;
      cycles_q <= '0;
    end else begin
      pcnt_q   <= pcnt_d;
      block_q  <= block_d;
      src_q    <= src_d;
      cycles_q <= cycles_d;
    end
  end

  assign mon.block         = block_q;
  assign mon.block_src_idx = src_q;
  assign mon.block_cycles  = cycles_q;

endmodule

// File: doc/pixel_dma_out_hls_deadlock_mon_mc.md
# pixel_dma_out_hls_deadlock_mon_mc

Parametrised deadlock monitor for HLS-generated dataflow regions in the pixel DMA output path. It watches N_AXIS stream-stall flags and N_INST sub-instance block/idle flags. It filters them through a consecutive-cycle persistence threshold and raises a registered `block` flag. At detection it captures which source stalled first and counts stalled cycles. It sits beside the top dataflow instance and drives the debug/interrupt aggregation logic.

## Interface
- N_AXIS, 1: number of AXI-stream stall inputs (≥1).
- N_INST, 2: number of sub-instances monitored (≥1).
- THRESH, 1: consecutive candidate cycles needed before `block` asserts (1 ≤ THRESH < 2^CNT_W).
- CNT_W, 16: width of the persistence counter and the stall-cycle counter.
- AXIS_MASK, {N_AXIS{1'b1}}: per-channel enable; a masked-out channel is ignored.
- IDX_W, $clog2(N_AXIS+N_INST) (min 1): width of the source index (derived; do not override).

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous clear of detection state and counters.
- axis_block_sigs  in  N_AXIS  per-stream stall flags.
- inst_idle_sigs  in  N_INST  per-instance idle flags.
- inst_block_sigs  in  N_INST  per-instance block flags.
- block  out  1  deadlock detected (registered).
- block_src_idx  out  IDX_W  source captured at detection.
- block_cycles  out  CNT_W  saturating count of cycles with `block` high.

## Operation
- Candidate: `cand = (|(axis_block_sigs & AXIS_MASK) | |inst_block_sigs) & ~(&inst_idle_sigs)`. When every instance is idle, the condition is suppressed.
- Persistence counter `pcnt`:
  - `cand`=0 → `pcnt` ← 0.
  - `cand`=1 → `pcnt` ← `pcnt`+1, saturating at THRESH.
- Detect: `det = cand & (pcnt == THRESH-1)`. With THRESH=1, `det = cand`.
- On `det` with `block`=0, `block_src_idx` ← encoding of the lowest-index asserted source:
  - An AXIS bit i (masked) encodes as i.
  - Otherwise an inst bit j encodes as N_AXIS+j.
  - The captured value holds until the next capture or clear.
- `block` next state:
  - Set when `cand & (pcnt ≥ THRESH-1)`.
  - Otherwise 0 (non-sticky build; see Configuration).
- `block_cycles` increments each cycle `block` is 1 and saturates at 2^CNT_W−1. It does not reset when `block` falls; only `clear` or reset zeroes it.
- `clear` priority: over set and increment in the same cycle. It zeroes `block`, `pcnt`, `block_src_idx` and `block_cycles`.

## Timing
- Reset values: `block`=0, `block_src_idx`=0, `block_cycles`=0, `pcnt`=0. Reset applies immediately, independent of `clock`.
- Assert latency: `cand` continuously high from cycle c rises `block` after the rising edge ending cycle c+THRESH−1. With THRESH=1, `block` rises one cycle after `cand`.
- Deassert, non-sticky: `block` falls at the edge after the first cycle with `cand`=0.
- A one-cycle gap in `cand` restarts persistence from 0.
- All-idle going true mid-stall is treated as `cand` falling.
- Reset asserted mid-stall clears all state. Detection restarts from zero after reset release.
- `block_cycles` lags `block` by one cycle: the first increment is visible the cycle after `block` rises.

## Configuration
- `HLS_DEADLOCK_MON_STICKY_EN` defined:
  - `block` latches at 1 once set.
  - It stays high regardless of `cand` until `clear` or reset.
  - `block_src_idx` is not recaptured while latched.
- Not defined: `block` tracks the persistence-filtered condition as above.

## Test plan
- N_AXIS=1, N_INST=2, THRESH=1: pulse axis_block_sigs=1 for 1 cycle with idle=2'b00.
  - Required: `block`=1 for exactly 1 cycle, one cycle later; `block_src_idx`=0; `block_cycles`=1.
- THRESH=4: hold inst_block_sigs[1]=1 for 3 cycles, drop 1 cycle, then hold 4 cycles.
  - Required: no assertion during the first run; `block` rises after the 4th cycle of the second run; `block_src_idx`=N_AXIS+1=2.
- inst_block_sigs=2'b11 with inst_idle_sigs=2'b11 for 10 cycles.
  - Required: `block` stays 0 throughout.
- N_AXIS=3, AXIS_MASK=3'b101: drive axis_block_sigs=3'b010, then 3'b110.
  - Required: no block for 3'b010; `block_src_idx`=2 for 3'b110.
- Sticky build: trigger block, drop `cand`, wait 5 cycles, pulse `clear` together with `cand`=1.
  - Required: `block` holds 1 until `clear`, then reads 0 with `block_cycles`=0; it re-asserts THRESH cycles later.
- Force `block_cycles` near saturation with CNT_W=4 and assert reset mid-stall.
  - Required: count holds at 15, then all outputs are 0 immediately on reset.
